// File: rtl/dmem_mmio.sv
// Data-side memory: word RAM (comb read, byte-lane write) plus MMIO TX FIFO, status and cycle counter.
// Optional feature macro DMEM_MMIO_CYCLE_CNT_EN builds the 64-bit cycle counter and its high-word shadow.
module dmem_mmio #(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_we,
  input  logic [2:0]  dmem_type,
  output logic [31:0] dmem_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign_err
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0]   mem [RAM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   fcnt_q, fcnt_d;
  logic          ovf_q, ovf_d, mis_q, mis_d;

  logic [1:0]    sz, off;
  logic [AW-1:0] idx;
  logic          mmio_hit, misal, mmio_ok, ram_we;
  logic [3:0]    be;
  logic [31:0]   wrep, ram_rd, status, cnt_lo, cnt_hi;
  logic          empty, full, pop, push_req, push_ok, ovf_set, st_wr;
  logic          unused_ok;

  assign unused_ok = dmem_type[2];
  assign sz        = dmem_type[1:0];
  assign off       = dmem_addr[3:2];
  assign idx       = dmem_addr[AW+1:2];
  assign mmio_hit  = (dmem_addr[31:4] == MMIO_BASE[31:4]);

  // MMIO accepts only aligned word accesses; anything else there is a misaligned access.
  always_comb begin
    if (mmio_hit)       misal = !sz[1] || (dmem_addr[1:0] != 2'b00);
    else if (sz[1])     misal = (dmem_addr[1:0] != 2'b00);
    else if (sz[0])     misal = dmem_addr[0];
    else                misal = 1'b0;
  end

  assign mmio_ok = mmio_hit && !misal;
  assign ram_we  = dmem_we && !mmio_hit && !misal;

  always_comb begin
    be   = 4'hF;
    wrep = dmem_wdata;
    case (sz)
      2'b00: begin
        be   = 4'b0001 << dmem_addr[1:0];
        wrep = {4{dmem_wdata[7:0]}};
      end
      2'b01: begin
        be   = dmem_addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{dmem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ram_rd = mem[idx] >> {dmem_addr[1:0], 3'b000};

  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  assign empty    = (fcnt_q == '0);
  assign full     = (fcnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop      = !empty && tx_ready;
  assign push_req = dmem_we && mmio_ok && (off == 2'd0);
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign st_wr    = dmem_we && mmio_ok && (off == 2'd1);

  assign tx_valid     = !empty;
  assign tx_data      = empty ? 8'h00 : fifo[rd_q];
  assign misalign_err = mis_q;
  assign status       = {20'h0, 4'(fcnt_q), 4'h0, mis_q, ovf_q, full, empty};

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) fifo[wr_q] <= dmem_wdata[7:0];
  end

  // Status clears take priority over a set arriving in the same cycle.
  always_comb begin
    wr_d   = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    fcnt_d = fcnt_q;
    if (push_ok && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!push_ok && pop) fcnt_d = fcnt_q - 1'b1;
    ovf_d = (st_wr && dmem_wdata[2]) ? 1'b0 : (ovf_q | ovf_set);
    mis_d = (st_wr && dmem_wdata[3]) ? 1'b0 : (mis_q | misal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
      ovf_q  <= ovf_d;
      mis_q  <= mis_d;
    end
  end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
  logic [63:0] cyc_q;
  logic [31:0] shadow_q;
  logic        cnt_lo_rd;

  assign cnt_lo_rd = !dmem_we && mmio_ok && (off == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q    <= '0;
      shadow_q <= '0;
    end else begin
      cyc_q <= cyc_q + 64'd1;
      if (cnt_lo_rd) shadow_q <= cyc_q[63:32];
    end
  end

  assign cnt_lo = cyc_q[31:0];
  assign cnt_hi = shadow_q;
`else
  assign cnt_lo = '0;
  assign cnt_hi = '0;
`endif

  always_comb begin
    dmem_data = '0;
    if (!misal) begin
      if (mmio_hit) begin
        case (off)
          2'd1:    dmem_data = status;
          2'd2:    dmem_data = cnt_lo;
          2'd3:    dmem_data = cnt_hi;
          default: dmem_data = '0;
        endcase
      end else begin
        dmem_data = ram_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM access, alignment, TX FIFO, status and cycle counter.
module tb_dmem_mmio;
  localparam logic [31:0] MB = 32'h1000_0000;
  localparam logic [2:0]  T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dmem_addr, dmem_wdata, dmem_data;
  logic        dmem_we;
  logic [2:0]  dmem_type;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, misalign_err;

  int checks = 0;
  int errors = 0;

  dmem_mmio dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_we      (dmem_we),
    .dmem_type    (dmem_type),
    .dmem_data    (dmem_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present one access at the falling edge; it is committed on the following rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic [2:0] t);
    @(negedge clk);
    dmem_addr  = a;
    dmem_wdata = wd;
    dmem_we    = we;
    dmem_type  = t;
    #1;
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 1'b0, T_W);
  endtask

  initial begin
    rst_n = 1'b0; tx_ready = 1'b0;
    dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_we = 1'b0; dmem_type = T_W;
    #2;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step(MB + 32'h4, 32'h0, 1'b0, T_W);
    chk("rst_status", dmem_data, 32'h1);

    // RAM word store and sub-word reads
    step(32'h10, 32'hA1B2C3D4, 1'b1, T_W);
    step(32'h11, 32'h0, 1'b0, T_BU);
    chk("lbu_11", {24'h0, dmem_data[7:0]}, 32'hC3);
    step(32'h12, 32'h0, 1'b0, T_HU);
    chk("lhu_12", {16'h0, dmem_data[15:0]}, 32'hA1B2);
    step(32'h13, 32'h000000EE, 1'b1, T_B);
    step(32'h10, 32'h0, 1'b0, T_W);
    chk("sb_13_lw", dmem_data, 32'hEEB2C3D4);
    step(32'h1010, 32'h0, 1'b0, T_W);
    chk("alias_lw", dmem_data, 32'hEEB2C3D4);

    // Read during write returns old word
    step(32'h20, 32'h11111111, 1'b1, T_W);
    step(32'h20, 32'h22222222, 1'b1, T_W);
    chk("rdw_old", dmem_data, 32'h11111111);
    step(32'h22, 32'h0000BEEF, 1'b1, T_H);
    step(32'h20, 32'h0, 1'b0, T_W);
    chk("sh_22_lw", dmem_data, 32'hBEEF2222);

    // Misaligned halfword store
    step(32'h11, 32'h0000FFFF, 1'b1, T_H);
    chk("mis_rd_zero", dmem_data, 32'h0);
    chk("mis_not_yet", {31'h0, misalign_err}, 32'h0);
    step(32'h10, 32'h0, 1'b0, T_W);
    chk("mis_no_write", dmem_data, 32'hEEB2C3D4);
    chk("mis_flag", {31'h0, misalign_err}, 32'h1);
    step(MB + 32'h4, 32'h0, 1'b0, T_W);
    chk("mis_status", dmem_data, 32'h9);
    step(MB + 32'h4, 32'h8, 1'b1, T_W);
    step(MB + 32'h4, 32'h0, 1'b0, T_W);
    chk("mis_clr_status", dmem_data, 32'h1);
    chk("mis_clr_flag", {31'h0, misalign_err}, 32'h0);

    // Byte-sized MMIO access is misaligned and does not push
    step(MB, 32'h77, 1'b1, T_B);
    step(MB + 32'h4, 32'h0, 1'b0, T_W);
    chk("mmio_b_status", dmem_data, 32'h9);
    step(MB + 32'h4, 32'h8, 1'b1, T_W);

    // Overfill with consumer stalled
    for (int i = 1; i <= 9; i++) step(MB, i, 1'b1, T_W);
    step(MB + 32'h4, 32'h0, 1'b0, T_W);
    chk("ovf_status", dmem_data, 32'h806);
    chk("ovf_head", {23'h0, tx_valid, tx_data}, 32'h101);
    step(MB + 32'h4, 32'h4, 1'b1, T_W);
    step(MB + 32'h4, 32'h0, 1'b0, T_W);
    chk("ovf_clr", dmem_data, 32'h802);
    for (int i = 1; i <= 8; i++) begin
      idle();
      tx_ready = 1'b1;
      chk($sformatf("drain_%0d", i), {23'h0, tx_valid, tx_data}, 32'h100 | i);
    end
    idle();
    chk("drain_empty", {23'h0, tx_valid, tx_data}, 32'h0);
    tx_ready = 1'b0;

    // Push into a full FIFO while the head is popped
    for (int i = 0; i < 8; i++) step(MB, 32'h10 + i, 1'b1, T_W);
    step(MB, 32'h55, 1'b1, T_W);
    tx_ready = 1'b1;
    step(MB + 32'h4, 32'h0, 1'b0, T_W);
    tx_ready = 1'b0;
    chk("full_pp_status", dmem_data, 32'h802);
    for (int i = 0; i < 8; i++) begin
      idle();
      tx_ready = 1'b1;
      chk($sformatf("pp_drain_%0d", i), {24'h0, tx_data}, (i == 7) ? 32'h55 : 32'h11 + i);
    end
    idle();
    tx_ready = 1'b0;
    chk("pp_empty", {31'h0, tx_valid}, 32'h0);

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    // Shadow holds the high word from the CNT_LO read edge
    @(negedge clk);
    force dut.cyc_q = 64'h0000_0005_FFFF_FFFF;
    dmem_addr = MB + 32'h8; dmem_wdata = 32'h0; dmem_we = 1'b0; dmem_type = T_W;
    #1;
    release dut.cyc_q;
    chk("cnt_lo", dmem_data, 32'hFFFFFFFF);
    idle();
    idle();
    step(MB + 32'hC, 32'h0, 1'b0, T_W);
    chk("cnt_hi_shadow", dmem_data, 32'h5);
`else
    step(MB + 32'h8, 32'h0, 1'b0, T_W);
    chk("cnt_lo_off", dmem_data, 32'h0);
    step(MB + 32'hC, 32'h0, 1'b0, T_W);
    chk("cnt_hi_off", dmem_data, 32'h0);
`endif

    // Reset in the middle of a drain
    for (int i = 0; i < 5; i++) step(MB, 32'h30 + i, 1'b1, T_W);
    step(32'h3, 32'h0, 1'b0, T_W);
    tx_ready = 1'b1;
    idle();
    chk("pre_rst_mis", {31'h0, misalign_err}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_rst_data", {24'h0, tx_data}, 32'h0);
    chk("mid_rst_mis", {31'h0, misalign_err}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tx_ready = 1'b0;
    step(MB + 32'h4, 32'h0, 1'b0, T_W);
    chk("post_rst_status", dmem_data, 32'h1);
`ifdef DMEM_MMIO_CYCLE_CNT_EN
    step(MB + 32'h8, 32'h0, 1'b0, T_W);
    chk("post_rst_cnt", dmem_data, 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
